// File: rtl/pop_scan_sequencer.sv
// Ramsey-fringe scan controller for the POP timer: steps free-precession time,
// discards settling cycles after each step and tags valid cycles for averaging.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for start; all strobes quiet
// PRELOAD  | one clock after load_defaults; clears counters
// SETTLE   | discarding SETTLE_CYCLES timer loops after a load or step
// DWELL    | recording CYCLES_PER_STEP valid loops at the current step
// STEP     | one clock; pulses freeprecess_plus and advances step_index
// FINISH   | one clock; pulses scan_done with load_defaults
module pop_scan_sequencer #(
  parameter int WIDTH           = 16,
  parameter int CYCLES_PER_STEP = 8,
  parameter int NUM_STEPS       = 50,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic             clk_2m5_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             cycle_end_i,
  output logic             load_defaults_o,
  output logic             freeprecess_plus_o,
  output logic             record_valid_o,
  output logic             busy_o,
  output logic             scan_done_o,
  output logic             scan_aborted_o,
  output logic [WIDTH-1:0] step_index_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRELOAD = 3'd1,
    S_SETTLE  = 3'd2,
    S_DWELL   = 3'd3,
    S_STEP    = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  localparam logic [WIDTH-1:0] SETTLE_N   = WIDTH'(SETTLE_CYCLES);
  localparam logic [WIDTH-1:0] DWELL_N    = WIDTH'(CYCLES_PER_STEP);
  localparam logic [WIDTH-1:0] LAST_STEP  = WIDTH'(NUM_STEPS - 1);
  localparam bit               HAS_SETTLE = (SETTLE_CYCLES > 0);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic             cycle_end_q;
  logic             load_q, load_d;
  logic             fp_q, fp_d;
  logic             rv_q, rv_d;
  logic             done_q, done_d;
  logic             abrt_q, abrt_d;

  logic             loop_edge;
  logic             abort_hit;
  logic [WIDTH-1:0] cnt_inc;
  state_t           after_load;

  assign loop_edge  = cycle_end_i & ~cycle_end_q;
  assign abort_hit  = abort_i & (state_q != S_IDLE);
  assign cnt_inc    = cnt_q + WIDTH'(1);
  assign after_load = HAS_SETTLE ? S_SETTLE : S_DWELL;

  always_ff @(posedge clk_2m5_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      step_q      <= '0;
      cycle_end_q <= 1'b0;
      load_q      <= 1'b0;
      fp_q        <= 1'b0;
      rv_q        <= 1'b0;
      done_q      <= 1'b0;
      abrt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      cycle_end_q <= cycle_end_i;
      load_q      <= load_d;
      fp_q        <= fp_d;
      rv_q        <= rv_d;
      done_q      <= done_d;
      abrt_q      <= abrt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          state_d = S_PRELOAD;
          step_d  = '0;
          cnt_d   = '0;
        end
      end
      S_PRELOAD: begin
        state_d = after_load;
        cnt_d   = '0;
      end
      S_SETTLE: begin
        if (loop_edge) begin
          if (cnt_inc == SETTLE_N) begin
            state_d = S_DWELL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_DWELL: begin
        if (loop_edge) begin
          if (cnt_inc == DWELL_N) begin
            cnt_d   = '0;
            state_d = (step_q == LAST_STEP) ? S_FINISH : S_STEP;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_STEP: begin
        step_d  = step_q + WIDTH'(1);
        cnt_d   = '0;
        state_d = after_load;
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Abort overrides every other transition; step_index is kept for readout.
    if (abort_hit) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      step_d  = step_q;
    end
  end

  always_comb begin
    load_d = 1'b0;
    fp_d   = 1'b0;
    rv_d   = 1'b0;
    done_d = 1'b0;
    abrt_d = 1'b0;
    if (abort_hit) begin
      load_d = 1'b1;
      abrt_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE:   load_d = start_i & ~abort_i;
        S_DWELL:  rv_d   = loop_edge;
        S_STEP:   fp_d   = 1'b1;
        S_FINISH: begin
          done_d = 1'b1;
          load_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign load_defaults_o    = load_q;
  assign freeprecess_plus_o = fp_q;
  assign record_valid_o     = rv_q;
  assign scan_done_o        = done_q;
  assign scan_aborted_o     = abrt_q;
  assign busy_o             = (state_q != S_IDLE);
  assign step_index_o       = step_q;

endmodule

// File: tb/tb_pop_scan_sequencer.sv
// Directed bench for pop_scan_sequencer: instance a with one settle cycle,
// instance b with none; both 3 cycles/step, 4 steps.
module tb_pop_scan_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0, abort_a = 1'b0, cycle_end_a = 1'b0;
  logic start_b = 1'b0, abort_b = 1'b0, cycle_end_b = 1'b0;
  logic load_a, fp_a, rv_a, busy_a, done_a, abrt_a;
  logic load_b, fp_b, rv_b, busy_b, done_b, abrt_b;
  logic [15:0] step_a, step_b;

  int n_chk = 0;
  int n_err = 0;
  int n_load_a, n_fp_a, n_rv_a, n_done_a, n_abrt_a;
  int n_load_b, n_fp_b, n_rv_b, n_done_b, n_abrt_b;

  always #5 clk = ~clk;

  pop_scan_sequencer #(.WIDTH(16), .CYCLES_PER_STEP(3), .NUM_STEPS(4), .SETTLE_CYCLES(1)) u_dut_a (
    .clk_2m5_i(clk), .reset_i(reset), .start_i(start_a), .abort_i(abort_a),
    .cycle_end_i(cycle_end_a), .load_defaults_o(load_a), .freeprecess_plus_o(fp_a),
    .record_valid_o(rv_a), .busy_o(busy_a), .scan_done_o(done_a),
    .scan_aborted_o(abrt_a), .step_index_o(step_a));

  pop_scan_sequencer #(.WIDTH(16), .CYCLES_PER_STEP(3), .NUM_STEPS(4), .SETTLE_CYCLES(0)) u_dut_b (
    .clk_2m5_i(clk), .reset_i(reset), .start_i(start_b), .abort_i(abort_b),
    .cycle_end_i(cycle_end_b), .load_defaults_o(load_b), .freeprecess_plus_o(fp_b),
    .record_valid_o(rv_b), .busy_o(busy_b), .scan_done_o(done_b),
    .scan_aborted_o(abrt_b), .step_index_o(step_b));

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // strobe counters, sampled mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (load_a) n_load_a++;
      if (fp_a)   n_fp_a++;
      if (rv_a)   n_rv_a++;
      if (done_a) n_done_a++;
      if (abrt_a) n_abrt_a++;
      if (load_b) n_load_b++;
      if (fp_b)   n_fp_b++;
      if (rv_b)   n_rv_b++;
      if (done_b) n_done_b++;
      if (abrt_b) n_abrt_b++;
      if (done_a) begin
        chk_eq("a_done_with_load", int'(load_a), 1);
        chk_eq("a_done_busy_low", int'(busy_a), 0);
      end
      if (done_b) begin
        chk_eq("b_done_with_load", int'(load_b), 1);
        chk_eq("b_done_busy_low", int'(busy_b), 0);
      end
    end
  end

  task automatic clr_counts();
    #1;
    n_load_a = 0; n_fp_a = 0; n_rv_a = 0; n_done_a = 0; n_abrt_a = 0;
    n_load_b = 0; n_fp_b = 0; n_rv_b = 0; n_done_b = 0; n_abrt_b = 0;
  endtask

  task automatic start_scan_a();
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    chk_eq("a_start_load", int'(load_a), 1);
    chk_eq("a_start_busy", int'(busy_a), 1);
    chk_eq("a_start_step0", int'(step_a), 0);
    start_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_a(input string tag, input int exp_rv);
    cycle_end_a = 1'b1;
    @(negedge clk);
    chk_eq(tag, int'(rv_a), exp_rv);
    cycle_end_a = 1'b0;
    repeat (19) @(negedge clk);
  endtask

  task automatic pulse_b(input string tag, input int exp_rv);
    cycle_end_b = 1'b1;
    @(negedge clk);
    chk_eq(tag, int'(rv_b), exp_rv);
    cycle_end_b = 1'b0;
    repeat (19) @(negedge clk);
  endtask

  initial begin
    clr_counts();
    repeat (3) @(negedge clk);
    chk_eq("rst_load", int'(load_a), 0);
    chk_eq("rst_busy", int'(busy_a), 0);
    chk_eq("rst_step", int'(step_a), 0);
    chk_eq("rst_rv", int'(rv_a), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // start and abort together in IDLE: nothing happens
    clr_counts();
    start_a = 1'b1; abort_a = 1'b1;
    repeat (3) @(negedge clk);
    chk_eq("sa_busy", int'(busy_a), 0);
    start_a = 1'b0; abort_a = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_eq("sa_load_cnt", n_load_a, 0);

    // full scan
    clr_counts();
    start_scan_a();
    for (int s = 0; s < 4; s++) begin
      chk_eq($sformatf("full_step_idx%0d", s), int'(step_a), s);
      pulse_a($sformatf("full_settle_s%0d", s), 0);
      for (int k = 0; k < 3; k++) pulse_a($sformatf("full_rv_s%0d_k%0d", s, k), 1);
    end
    #1;
    chk_eq("full_load_cnt", n_load_a, 2);
    chk_eq("full_rv_cnt", n_rv_a, 12);
    chk_eq("full_fp_cnt", n_fp_a, 3);
    chk_eq("full_done_cnt", n_done_a, 1);
    chk_eq("full_abrt_cnt", n_abrt_a, 0);
    chk_eq("full_step_final", int'(step_a), 3);
    chk_eq("full_busy_end", int'(busy_a), 0);

    // abort in DWELL at step 2
    clr_counts();
    start_scan_a();
    for (int s = 0; s < 2; s++) begin
      pulse_a("ab_settle", 0);
      for (int k = 0; k < 3; k++) pulse_a("ab_rv", 1);
    end
    pulse_a("ab_settle2", 0);
    pulse_a("ab_rv2", 1);
    abort_a = 1'b1;
    @(negedge clk);
    chk_eq("ab_load", int'(load_a), 1);
    chk_eq("ab_aborted", int'(abrt_a), 1);
    chk_eq("ab_busy", int'(busy_a), 0);
    chk_eq("ab_step", int'(step_a), 2);
    chk_eq("ab_fp", int'(fp_a), 0);
    abort_a = 1'b0;
    pulse_a("ab_idle_rv0", 0);
    pulse_a("ab_idle_rv1", 0);
    #1;
    chk_eq("ab_rv_cnt", n_rv_a, 7);
    chk_eq("ab_fp_cnt", n_fp_a, 2);
    chk_eq("ab_load_cnt", n_load_a, 2);
    chk_eq("ab_abrt_cnt", n_abrt_a, 1);
    chk_eq("ab_done_cnt", n_done_a, 0);
    chk_eq("ab_step_hold", int'(step_a), 2);

    // stretched cycle_end counts once
    clr_counts();
    start_scan_a();
    pulse_a("st_settle", 0);
    cycle_end_a = 1'b1;
    @(negedge clk);
    chk_eq("st_rv_first", int'(rv_a), 1);
    repeat (4) @(negedge clk);
    cycle_end_a = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk_eq("st_rv_cnt", n_rv_a, 1);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    @(negedge clk);

    // async reset during SETTLE, then restart with start held
    start_scan_a();
    repeat (3) @(negedge clk);
    chk_eq("rr_busy_before", int'(busy_a), 1);
    #2 reset = 1'b1;
    #1;
    chk_eq("rr_busy_async", int'(busy_a), 0);
    chk_eq("rr_load_async", int'(load_a), 0);
    chk_eq("rr_step_async", int'(step_a), 0);
    start_a = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_eq("rr_restart_load", int'(load_a), 1);
    chk_eq("rr_restart_busy", int'(busy_a), 1);
    start_a = 1'b0;
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    repeat (2) @(negedge clk);

    // no settle cycles: every loop is recorded
    clr_counts();
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    chk_eq("b_start_load", int'(load_b), 1);
    start_b = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      chk_eq($sformatf("b_step_idx%0d", s), int'(step_b), s);
      for (int k = 0; k < 3; k++) pulse_b($sformatf("b_rv_s%0d_k%0d", s, k), 1);
    end
    #1;
    chk_eq("b_rv_cnt", n_rv_b, 12);
    chk_eq("b_fp_cnt", n_fp_b, 3);
    chk_eq("b_done_cnt", n_done_b, 1);
    chk_eq("b_load_cnt", n_load_b, 2);
    chk_eq("b_busy_end", int'(busy_b), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pop_scan_sequencer.md
Name: pop_scan_sequencer

Overview:
- Automatic Ramsey-fringe scan controller for the POP timer block.
- Drives the timer's free-precession increment strobe and its load-defaults strobe.
- Counts completed POP cycles using the timer's end-of-cycle (loop) pulse. Discards settling cycles after each step and tags valid cycles for downstream averaging.
- Replaces manual button stepping of free-precession time. Sits beside the timer on the 2.5 MHz domain.

Parameters:
- WIDTH, 16, width of step index and cycle counters.
- CYCLES_PER_STEP, 8, valid POP cycles recorded per free-precession step (>=1).
- NUM_STEPS, 50, number of free-precession values in one scan (>=1).
- SETTLE_CYCLES, 2, POP cycles discarded after load or step (0 = none).

Ports:
- clk_2M5  in  1  2.5 MHz system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level; sampled only in IDLE; high begins a scan.
- abort  in  1  level; high in any non-IDLE state terminates the scan.
- cycle_end  in  1  timer loop indication; rising edge = one completed POP cycle.
- load_defaults  out  1  one-cycle pulse; restores timer preset values.
- freeprecess_plus  out  1  one-cycle pulse; one free-precession increment.
- record_valid  out  1  one-cycle pulse per counted cycle in DWELL.
- busy  out  1  high in every state except IDLE.
- scan_done  out  1  one-cycle pulse on normal completion.
- scan_aborted  out  1  one-cycle pulse on abort.
- step_index  out  WIDTH  current step number, 0..NUM_STEPS-1.

Behaviour:
- Reset (async assert, sync release to next posedge): all outputs 0, step_index 0, counters 0, state IDLE, cycle_end edge register 0.
- cycle_end edge detect:
  - One register on posedge; edge = cycle_end & !cycle_end_d.
  - Level held high over several clocks counts once.
  - Edge is used one clock after cycle_end rises.
- States: IDLE, PRELOAD, SETTLE, DWELL, STEP, FINISH.
- IDLE:
  - start=1 and abort=0 -> PRELOAD.
  - load_defaults pulses on the next clock edge; step_index cleared to 0.
- PRELOAD:
  - Lasts exactly 1 clock.
  - -> SETTLE if SETTLE_CYCLES>0, else -> DWELL.
  - Settle and dwell counters cleared.
- SETTLE:
  - Count cycle_end edges.
  - At the edge making the count == SETTLE_CYCLES -> DWELL, counter cleared.
  - No record_valid in this state.
- DWELL:
  - Each cycle_end edge pulses record_valid, registered (1 clock after the edge is detected), and increments the dwell count.
  - At the edge making the count == CYCLES_PER_STEP:
    - step_index == NUM_STEPS-1 -> FINISH.
    - Otherwise -> STEP.
- STEP:
  - Lasts 1 clock.
  - freeprecess_plus pulses 1 clock; step_index increments on the same edge.
  - -> SETTLE, or -> DWELL if SETTLE_CYCLES==0.
- FINISH:
  - Lasts 1 clock.
  - scan_done and load_defaults pulse together; step_index held at final value.
  - -> IDLE.
- Abort:
  - abort=1 in any non-IDLE state takes priority over all other transitions that clock.
  - Next edge: load_defaults=1, scan_aborted=1, freeprecess_plus=0, record_valid=0.
  - -> IDLE; step_index held for readout.
- Precedence:
  - start and abort both high in IDLE: stay IDLE, no pulses.
  - start held high after FINISH or abort: a new scan begins on the first IDLE clock with start=1.
- A cycle_end edge arriving in PRELOAD, STEP or FINISH is ignored (not counted).
- Output strobes are registered; never more than one clock wide.
- Counters saturate-free: counts never exceed their parameter bound because the state exits at equality.
- reset asserted mid-scan: immediate return to reset values, no load_defaults pulse.

Test Plan (CYCLES_PER_STEP=3, NUM_STEPS=4, SETTLE_CYCLES=1; cycle_end pulsed 1 clock every 20 clocks):
- Full scan: start 1-clock pulse ->
  - 1 load_defaults at start;
  - exactly 16 cycle_end edges consumed;
  - 12 record_valid, 3 freeprecess_plus;
  - step_index sequence 0,1,2,3;
  - 1 scan_done coincident with a second load_defaults;
  - busy falls the same clock.
- Settle discard: after each freeprecess_plus, the first cycle_end produces no record_valid; the next 3 each produce one, 1 clock after the edge.
- Abort mid-DWELL at step 2 -> next clock: load_defaults=1, scan_aborted=1; state IDLE; step_index=2; no further strobes.
- Stretched cycle_end held high 5 clocks -> counted once (single record_valid).
- start and abort both high in IDLE -> no outputs change, busy stays 0. SETTLE_CYCLES=0 rerun -> 12 record_valid from 12 edges, 3 freeprecess_plus.
- Async reset asserted between clock edges during SETTLE -> all outputs 0 immediately. After release with start=1 -> a fresh scan starting with load_defaults.
